// File: rtl/core_pkg.sv
// Shared constants and types for the write-back path into the 32x32 register file.
package core_pkg;
   localparam int XLEN = 32;
   localparam int NREG = 32;
   localparam int AW   = 5;

   typedef enum logic {
      REQ_ALU = 1'b0,
      REQ_LSU = 1'b1
   } req_e;

   typedef struct packed {
      logic            valid;
      logic [AW-1:0]   rd;
      logic [XLEN-1:0] wd;
   } wb_req_t;
endpackage

// File: rtl/wb_rr_arb2.sv
// Two-way round-robin arbiter for the write-back port.
// A single requester always wins; on a tie the one not served last wins.
module wb_rr_arb2
   import core_pkg::*;
(
   input  logic alu_valid,
   input  logic lsu_valid,
   input  req_e last,
   output logic alu_grant,
   output logic lsu_grant
);

   // Grant decode from the valid pair and the round-robin history.
   always_comb begin
      alu_grant = 1'b0;
      lsu_grant = 1'b0;
      case ({alu_valid, lsu_valid})
         2'b10: alu_grant = 1'b1;
         2'b01: lsu_grant = 1'b1;
         2'b11: begin
            if (last == REQ_ALU) begin
               lsu_grant = 1'b1;
            end else begin
               alu_grant = 1'b1;
            end
         end
         default: begin
            alu_grant = 1'b0;
            lsu_grant = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Write-back controller: arbitrates ALU/LSU results onto the regfile write port
// and tracks pending destinations to stall decode on RAW/WAW hazards.
module regfile_wb_ctrl
   import core_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            iss_valid,
   input  logic [AW-1:0]   iss_rd,
   input  logic [AW-1:0]   iss_rs1,
   input  logic [AW-1:0]   iss_rs2,
   output logic            hazard,
   input  logic            alu_valid,
   output logic            alu_ready,
   input  logic [AW-1:0]   alu_rd,
   input  logic [XLEN-1:0] alu_wd,
   input  logic            lsu_valid,
   output logic            lsu_ready,
   input  logic [AW-1:0]   lsu_rd,
   input  logic [XLEN-1:0] lsu_wd,
   output logic            rf_we,
   output logic [AW-1:0]   rf_rd,
   output logic [XLEN-1:0] rf_wd,
   output logic [NREG-1:0] busy
);

   wb_req_t         win_req_s;
   logic            alu_grant_s;
   logic            lsu_grant_s;
   logic            xfer_s;
   logic            issue_s;
   logic [NREG-1:0] set_s;
   logic [NREG-1:0] clr_s;
   logic [NREG-1:0] busy_nxt_s;
   logic [NREG-1:0] busy_r;
   req_e            last_r;

   wb_rr_arb2 u_arb (
      .alu_valid (alu_valid),
      .lsu_valid (lsu_valid),
      .last      (last_r),
      .alu_grant (alu_grant_s),
      .lsu_grant (lsu_grant_s)
   );

   // Grants are suppressed while in reset so nothing is accepted and then lost.
   always_comb begin
      alu_ready = alu_grant_s & ~rst;
      lsu_ready = lsu_grant_s & ~rst;
      if (lsu_ready) begin
         win_req_s = '{valid: lsu_valid, rd: lsu_rd, wd: lsu_wd};
      end else if (alu_ready) begin
         win_req_s = '{valid: alu_valid, rd: alu_rd, wd: alu_wd};
      end else begin
         win_req_s = {1'b0, {AW{1'b0}}, {XLEN{1'b0}}};
      end
      xfer_s = win_req_s.valid;
   end

   // Round-robin history: remember who was served on the last handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_r <= REQ_LSU;
      end else if (alu_ready) begin
         last_r <= REQ_ALU;
      end else if (lsu_ready) begin
         last_r <= REQ_LSU;
      end else begin
         last_r <= last_r;
      end
   end

   // Write stage; an x0 destination completes the handshake but never writes.
   always_ff @(posedge clk) begin
      if (rst) begin
         rf_we <= 1'b0;
         rf_rd <= {AW{1'b0}};
         rf_wd <= {XLEN{1'b0}};
      end else if (xfer_s) begin
         rf_we <= (win_req_s.rd != {AW{1'b0}});
         rf_rd <= win_req_s.rd;
         rf_wd <= win_req_s.wd;
      end else begin
         rf_we <= 1'b0;
      end
   end

   // Stall decode on pending sources (RAW) or a pending destination (WAW).
   always_comb begin
      hazard = ((iss_rs1 != {AW{1'b0}}) && busy_r[iss_rs1]) ||
               ((iss_rs2 != {AW{1'b0}}) && busy_r[iss_rs2]) ||
               (iss_valid && (iss_rd != {AW{1'b0}}) && busy_r[iss_rd]);
   end

   // Scoreboard update: clear on commit, set on issue; set applied last so it wins.
   always_comb begin
      set_s   = {NREG{1'b0}};
      clr_s   = {NREG{1'b0}};
      issue_s = iss_valid && !hazard && (iss_rd != {AW{1'b0}});
      if (rf_we) begin
         clr_s[rf_rd] = 1'b1;
      end else begin
         clr_s = {NREG{1'b0}};
      end
      if (issue_s) begin
         set_s[iss_rd] = 1'b1;
      end else begin
         set_s = {NREG{1'b0}};
      end
      busy_nxt_s = ((busy_r & ~clr_s) | set_s) & ~{{(NREG-1){1'b0}}, 1'b1};
   end

   // Scoreboard register.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_r <= {NREG{1'b0}};
      end else begin
         busy_r <= busy_nxt_s;
      end
   end

   assign busy = busy_r;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Scoreboard bench for regfile_wb_ctrl: directed scenarios followed by random traffic.
module tb_regfile_wb_ctrl;
   import core_pkg::*;

   logic            clk = 1'b0;
   logic            rst;
   logic            iss_valid;
   logic [AW-1:0]   iss_rd, iss_rs1, iss_rs2;
   logic            hazard;
   logic            alu_valid, alu_ready;
   logic [AW-1:0]   alu_rd;
   logic [XLEN-1:0] alu_wd;
   logic            lsu_valid, lsu_ready;
   logic [AW-1:0]   lsu_rd;
   logic [XLEN-1:0] lsu_wd;
   logic            rf_we;
   logic [AW-1:0]   rf_rd;
   logic [XLEN-1:0] rf_wd;
   logic [NREG-1:0] busy;

   regfile_wb_ctrl dut (
      .clk(clk), .rst(rst),
      .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
      .hazard(hazard),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_wd(alu_wd),
      .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_wd(lsu_wd),
      .rf_we(rf_we), .rf_rd(rf_rd), .rf_wd(rf_wd), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int              due;
      logic [AW-1:0]   rd;
      logic [XLEN-1:0] wd;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;

   // Reference model: pending set as a bit array, who was served last, write committing now.
   logic [NREG-1:0] busy_m = '0;
   int              last_m = 1;   // 0 = ALU served last, 1 = LSU served last
   logic [AW-1:0]   commit_m = 5'd0;
   bit              alu_taken = 1'b0;
   bit              lsu_taken = 1'b0;
   logic            mon_exp_we;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every cycle compare the write port against the head of the expected queue.
   always @(negedge clk) begin
      mon_exp_we = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      check("rf_we", {63'd0, rf_we}, {63'd0, mon_exp_we});
      if (mon_exp_we) begin
         if (rf_we === 1'b1) begin
            check("rf_rd", {59'd0, rf_rd}, {59'd0, exp_q[0].rd});
            check("rf_wd", {32'd0, rf_wd}, {32'd0, exp_q[0].wd});
         end
         void'(exp_q.pop_front());
      end
   end

   // Check combinational outputs, predict this cycle's handshake and advance the model.
   task automatic predict();
      bit              hz, ga, gl;
      logic [NREG-1:0] nb;
      exp_t            e;
      hz = (iss_rs1 != 5'd0 && busy_m[iss_rs1]) || (iss_rs2 != 5'd0 && busy_m[iss_rs2]) ||
           (iss_valid && iss_rd != 5'd0 && busy_m[iss_rd]);
      check("hazard", {63'd0, hazard}, {63'd0, hz});
      check("busy", {32'd0, busy}, {32'd0, busy_m});
      ga = 1'b0;
      gl = 1'b0;
      if (!rst) begin
         if (alu_valid && lsu_valid) begin
            if (last_m == 1) ga = 1'b1;
            else gl = 1'b1;
         end else if (alu_valid) ga = 1'b1;
         else if (lsu_valid) gl = 1'b1;
      end
      check("alu_ready", {63'd0, alu_ready}, {63'd0, ga});
      check("lsu_ready", {63'd0, lsu_ready}, {63'd0, gl});
      alu_taken = ga;
      lsu_taken = gl;
      nb = busy_m;
      if (commit_m != 5'd0) nb[commit_m] = 1'b0;
      if (iss_valid && !hz && iss_rd != 5'd0) nb[iss_rd] = 1'b1;
      commit_m = 5'd0;
      if (ga) begin
         last_m = 0;
         if (alu_rd != 5'd0) begin
            e.due = cyc + 1; e.rd = alu_rd; e.wd = alu_wd;
            exp_q.push_back(e);
            commit_m = alu_rd;
         end
      end
      if (gl) begin
         last_m = 1;
         if (lsu_rd != 5'd0) begin
            e.due = cyc + 1; e.rd = lsu_rd; e.wd = lsu_wd;
            exp_q.push_back(e);
            commit_m = lsu_rd;
         end
      end
      if (rst) begin
         nb = '0;
         last_m = 1;
         commit_m = 5'd0;
      end
      busy_m = nb;
   endtask

   task automatic tick();
      @(negedge clk); #1;
      predict();
      @(posedge clk); #1;
   endtask

   // Requesters keep rd/wd stable until granted.
   task automatic rand_inputs();
      if (alu_taken || !alu_valid) begin
         alu_valid = ($urandom % 3) != 0;
         alu_rd    = 5'($urandom % 8);
         alu_wd    = $urandom;
      end
      if (lsu_taken || !lsu_valid) begin
         lsu_valid = ($urandom % 3) != 0;
         lsu_rd    = 5'($urandom % 8);
         lsu_wd    = $urandom;
      end
      iss_valid = ($urandom % 2) != 0;
      iss_rd    = 5'($urandom % 8);
      iss_rs1   = 5'($urandom % 8);
      iss_rs2   = 5'($urandom % 8);
      rst       = ($urandom % 64) == 0;
   endtask

   initial begin
      // Reset with both requesters valid, then contention with strict alternation.
      rst = 1'b1; iss_valid = 1'b0; iss_rd = 5'd0; iss_rs1 = 5'd0; iss_rs2 = 5'd0;
      alu_valid = 1'b1; alu_rd = 5'd1; alu_wd = 32'hA1;
      lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_wd = 32'hB2;
      tick(); tick();
      rst = 1'b0;
      tick();
      alu_rd = 5'd3; alu_wd = 32'hA3;
      tick();
      lsu_rd = 5'd4; lsu_wd = 32'hB4;
      tick();
      alu_valid = 1'b0;
      tick();
      lsu_valid = 1'b0;
      // Single ALU write to x5.
      iss_valid = 1'b1; iss_rd = 5'd5;
      tick();
      iss_valid = 1'b0; alu_valid = 1'b1; alu_rd = 5'd5; alu_wd = 32'hDEADBEEF;
      tick();
      alu_valid = 1'b0;
      tick(); tick();
      // RAW stall on x7, then an x0 issue that must not mark anything busy.
      iss_valid = 1'b1; iss_rd = 5'd7;
      tick();
      iss_valid = 1'b0; iss_rs2 = 5'd7;
      tick(); tick();
      lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_wd = 32'h77;
      tick();
      lsu_valid = 1'b0;
      tick(); tick();
      iss_rs2 = 5'd0; iss_rs1 = 5'd0; iss_valid = 1'b1; iss_rd = 5'd0;
      tick();
      iss_valid = 1'b0;
      tick();
      // WAW on x9: issue blocked while the write commits, accepted the next cycle.
      iss_valid = 1'b1; iss_rd = 5'd9;
      tick();
      iss_valid = 1'b0; alu_valid = 1'b1; alu_rd = 5'd9; alu_wd = 32'h99;
      tick();
      alu_valid = 1'b0; iss_valid = 1'b1; iss_rd = 5'd9;
      tick(); tick();
      iss_valid = 1'b0;
      tick();
      // Write-back to x0 handshakes but never writes.
      alu_valid = 1'b1; alu_rd = 5'd0; alu_wd = 32'h1234;
      tick();
      alu_valid = 1'b0;
      tick();
      // Same-edge clear and set of x10: set wins.
      lsu_valid = 1'b1; lsu_rd = 5'd10; lsu_wd = 32'h10;
      tick();
      lsu_valid = 1'b0; iss_valid = 1'b1; iss_rd = 5'd10;
      tick();
      iss_valid = 1'b0;
      tick();
      // Reset right after a transfer.
      iss_valid = 1'b1; iss_rd = 5'd12;
      tick();
      iss_valid = 1'b0; alu_valid = 1'b1; alu_rd = 5'd3; alu_wd = 32'h33;
      tick();
      alu_valid = 1'b0; rst = 1'b1;
      tick();
      rst = 1'b0;
      tick(); tick();
      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         rand_inputs();
         tick();
      end
      rst = 1'b0; alu_valid = 1'b0; lsu_valid = 1'b0; iss_valid = 1'b0;
      tick(); tick(); tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/regfile_wb_ctrl.md
Name: regfile_wb_ctrl

Overview:
- Write-back controller for the 32x32 single-write-port register file.
- Arbitrates two write-back requesters onto the regfile write port (we/rd/wd): the ALU and the load/store unit.
- Arbitration is round-robin with a valid/ready handshake.
- Keeps a busy scoreboard of pending destination registers and raises a hazard stall to decode on RAW/WAW conflicts.
- Sits between execute/LSU and the regfile write port; decode sees the hazard output.

Parameters:
- XLEN, 32, data width of write-back values.
- NREG, 32, number of architectural registers.
- AW, 5, register index width; must satisfy 2^AW = NREG.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- iss_valid  in  1  decode issuing an instruction that will write iss_rd.
- iss_rd  in  AW  destination of the issuing instruction.
- iss_rs1  in  AW  source 1 of the instruction in decode.
- iss_rs2  in  AW  source 2 of the instruction in decode.
- hazard  out  1  combinational stall to decode.
- alu_valid  in  1  ALU write-back request.
- alu_ready  out  1  ALU request granted this cycle.
- alu_rd  in  AW  ALU destination.
- alu_wd  in  XLEN  ALU result.
- lsu_valid  in  1  load write-back request.
- lsu_ready  out  1  load request granted this cycle.
- lsu_rd  in  AW  load destination.
- lsu_wd  in  XLEN  load data.
- rf_we  out  1  regfile write enable (registered).
- rf_rd  out  AW  regfile write index (registered).
- rf_wd  out  XLEN  regfile write data (registered).
- busy  out  NREG  scoreboard; bit i set means a write to xi is pending.

Behaviour:
- Reset values:
  - rf_we=0, rf_rd=0, rf_wd=0, busy=0.
  - Round-robin pointer last=LSU, so the ALU wins the first tie.
  - A pending write stage is discarded when rst is asserted mid-operation.
- Arbitration (combinational):
  - Exactly one requester is granted when at least one is valid.
  - Only ALU valid -> alu_ready=1. Only LSU valid -> lsu_ready=1.
  - Both valid -> grant the requester not equal to last.
  - Neither valid -> both ready=0.
  - ready never asserts without the matching valid.
  - last updates to the granted requester on a handshake.
- Handshake:
  - A transfer occurs when valid && ready at posedge.
  - Requesters hold rd/wd stable while valid && !ready.
- Write stage (1-cycle latency):
  - A transfer at edge N drives rf_we=1 and rf_rd/rf_wd = granted rd/wd for cycle N..N+1.
  - The regfile commits on edge N+1.
  - With no transfer, rf_we=0 and rf_rd/rf_wd hold their values.
- rd=0 requests:
  - Handshake completes; rf_we stays 0. The write is dropped.
- Scoreboard:
  - Set busy[iss_rd] at posedge when iss_valid && !hazard && iss_rd!=0.
  - Clear busy[rf_rd] at posedge when rf_we=1, which is the same edge the regfile commits.
  - Set and clear of the same index on the same edge -> set wins.
  - busy[0] is constant 0.
  - A write-back to a non-busy register is legal; the write still occurs and busy is unchanged.
- Hazard (combinational):
  - hazard = (iss_rs1!=0 && busy[iss_rs1]) || (iss_rs2!=0 && busy[iss_rs2]) || (iss_valid && iss_rd!=0 && busy[iss_rd]).
  - No bypass: a source becomes readable the cycle after its busy bit clears.
- Throughput:
  - One write per cycle sustained.
  - With both requesters continuously valid, grants strictly alternate.

Decomposition:
- Shared package core_pkg holds:
  - XLEN, NREG, AW constants.
  - wb_req_t struct {valid, rd, wd}.
  - Requester enum {REQ_ALU, REQ_LSU}.
- One natural sub-module, wb_rr_arb2: the 2-way round-robin arbiter (valids and last in, grants out). The scoreboard and write stage stay in the top level.

Test Plan:
1. Reset: assert rst 2 cycles with both valids high -> rf_we=0, busy=0, alu_ready=lsu_ready=0 during reset; first cycle after reset, both valid -> alu_ready=1.
2. Single ALU write: iss_valid, iss_rd=5 -> busy[5]=1; alu_valid, rd=5, wd=0xDEADBEEF -> next cycle rf_we=1, rf_rd=5, rf_wd=0xDEADBEEF; after that edge busy[5]=0.
3. Contention: ALU and LSU valid for 4 cycles (rd 1..4) -> grants ALU, LSU, ALU, LSU; rf_we high 4 consecutive cycles; no request lost or duplicated.
4. RAW stall: busy[7]=1, iss_rs2=7 -> hazard=1 until the edge committing x7; iss_rs1=0 with busy[0] forced attempt -> hazard=0.
5. WAW plus same-edge set/clear: rf_we writing x9 while issue of rd=9 is blocked by hazard; issue next cycle -> busy[9]=1 again; rd=0 write-back -> ready=1, rf_we=0.
6. Reset mid-operation: transfer at edge N, rst at N+1 -> rf_we=0 and busy=0 after the edge; no write to the regfile.
